mrelbp_ci_core: RTL and testbench

//  Parametrised central-intensity (CI) bit generator for the MRELBP feature path.

---
 rtl/mrelbp_pkg.sv | 18 +
 rtl/ci_adder_tree.sv | 14 +
 rtl/mrelbp_ci_core.sv | 88 ++++++++
 tb/tb_mrelbp_ci_core.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mrelbp_pkg.sv
// mrelbp_pkg: shared clog2 helper, default CI widths and mode encodings
package mrelbp_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  localparam int CI_DW = 8;
  localparam int CI_NS = 9;
  localparam int CI_COLS = 11;
  localparam int CI_ROWS = 11;
  localparam int CI_PIX = CI_COLS * CI_ROWS;
  localparam int CI_SW = CI_DW + clog2(CI_NS);
  localparam int CI_GW = CI_DW + clog2(CI_PIX);
  localparam logic CI_MODE_LOCAL = 1'b0;
  localparam logic CI_MODE_GLOBAL = 1'b1;
endpackage

// File: rtl/ci_adder_tree.sv
// ci_adder_tree: combinational sum of NS DW-bit samples (samples_i) into SW-bit sum_o
module ci_adder_tree #(
  parameter int DW = 8,
  parameter int NS = 9,
  parameter int SW = 12
) (
  input  logic [NS*DW-1:0] samples_i,
  output logic [SW-1:0]    sum_o
);
  always_comb begin
    sum_o = '0;
    for (int k = 0; k < NS; k++) sum_o = sum_o + SW'(samples_i[k*DW +: DW]);
  end
endmodule

// File: rtl/mrelbp_ci_core.sv
// mrelbp_ci_core: 2-cycle CI bit generator (local window mean or previous-frame global mean); in valid_i/samples_i/center_i/mode_i, out ci_o/valid_o/frame_done_o/gvalid_o
module mrelbp_ci_core
  import mrelbp_pkg::*;
#(
  parameter int DW = CI_DW,
  parameter int NS = CI_NS,
  parameter int COLS = CI_COLS,
  parameter int ROWS = CI_ROWS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [NS*DW-1:0] samples_i,
  input  logic [DW-1:0]    center_i,
  input  logic             mode_i,
  output logic             ci_o,
  output logic             valid_o,
  output logic             frame_done_o,
  output logic             gvalid_o
);
  localparam int PIX = COLS * ROWS;
  localparam int SW = DW + clog2(NS);
  localparam int GW = DW + clog2(PIX);
  localparam int OW = SW > GW ? SW : GW;
  localparam int CW = PIX > 1 ? clog2(PIX) : 1;
  logic [SW-1:0] w_sum;
  logic          w_first, w_last, w_glob;
  logic [OW-1:0] w_lhs, w_rhs;
  logic [CW-1:0] r_cnt;
  logic          r_mode, r_gvalid;
  logic [GW-1:0] r_acc, r_gsum;
  logic          r1_valid, r1_last, r1_glob, r1_gvalid;
  logic [OW-1:0] r1_lhs, r1_rhs;
  logic          r_ci, r_valid, r_fd;
  ci_adder_tree #(.DW(DW), .NS(NS), .SW(SW)) u_sum (
    .samples_i(samples_i),
    .sum_o    (w_sum)
  );
  always_comb begin
    w_first = r_cnt == '0;
    w_last  = r_cnt == CW'(PIX - 1);
    w_glob  = (w_first ? mode_i : r_mode) == CI_MODE_GLOBAL;
    w_lhs   = w_glob ? OW'(GW'(center_i) * GW'(PIX)) : OW'(SW'(center_i) * SW'(NS));
    w_rhs   = w_glob ? OW'(r_gsum) : OW'(w_sum);
  end
  // r_gsum is snapshotted into stage 1, so the last pixel of a frame still sees the old total
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_mode    <= CI_MODE_LOCAL;
      r_gvalid  <= 1'b0;
      r_acc     <= '0;
      r_gsum    <= '0;
      r1_valid  <= 1'b0;
      r1_last   <= 1'b0;
      r1_glob   <= 1'b0;
      r1_gvalid <= 1'b0;
      r1_lhs    <= '0;
      r1_rhs    <= '0;
      r_ci      <= 1'b0;
      r_valid   <= 1'b0;
      r_fd      <= 1'b0;
    end else begin
      r1_valid  <= valid_i;
      r1_last   <= valid_i && w_last;
      r1_glob   <= w_glob;
      r1_gvalid <= r_gvalid;
      r1_lhs    <= w_lhs;
      r1_rhs    <= w_rhs;
      r_valid   <= r1_valid;
      r_fd      <= r1_last;
      r_ci      <= r1_valid && !(r1_glob && !r1_gvalid) && r1_lhs >= r1_rhs;
      if (valid_i) begin
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        r_acc <= w_last ? '0 : r_acc + GW'(center_i);
        if (w_first) r_mode <= mode_i;
        if (w_last) begin
          r_gsum   <= r_acc + GW'(center_i);
          r_gvalid <= 1'b1;
        end
      end
    end
  end
  assign ci_o         = r_ci;
  assign valid_o      = r_valid;
  assign frame_done_o = r_fd;
  assign gvalid_o     = r_gvalid;
endmodule

// File: tb/tb_mrelbp_ci_core.sv
// tb_mrelbp_ci_core: scoreboard bench for mrelbp_ci_core with 4x4 frames
module tb_mrelbp_ci_core;
  localparam int DW = 8;
  localparam int NS = 9;
  typedef struct {
    logic ci;
    logic fd;
    int   cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_i = 1'b0;
  logic [NS*DW-1:0] samples_i = '0;
  logic [DW-1:0] center_i = '0;
  logic mode_i = 1'b0;
  logic ci_o, valid_o, frame_done_o, gvalid_o;
  exp_t sb[$];
  int cyc = 0;
  int pcnt = 0;
  int n_pass = 0;
  int n_total = 0;
  int fd_cnt = 0;
  mrelbp_ci_core #(.DW(DW), .NS(NS), .COLS(4), .ROWS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .samples_i   (samples_i),
    .center_i    (center_i),
    .mode_i      (mode_i),
    .ci_o        (ci_o),
    .valid_o     (valid_o),
    .frame_done_o(frame_done_o),
    .gvalid_o    (gvalid_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done_o) fd_cnt++;
      if (valid_o) begin
        if (sb.size() == 0) chk("unexpected_valid_o", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ci_o", int'(ci_o), int'(e.ci));
          chk("frame_done_o", int'(frame_done_o), int'(e.fd));
          chk("latency_cycle", cyc, e.cyc);
        end
      end else if (frame_done_o) chk("frame_done_without_valid", 1, 0);
    end
  end
  function automatic logic [NS*DW-1:0] fill(input logic [DW-1:0] v);
    return {NS{v}};
  endfunction
  function automatic logic [NS*DW-1:0] ramp();
    logic [NS*DW-1:0] r;
    for (int k = 0; k < NS; k++) r[k*DW +: DW] = DW'(k);
    return r;
  endfunction
  task automatic send(input logic [DW-1:0] c, input logic [NS*DW-1:0] s, input logic m, input logic e);
    exp_t x;
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    samples_i = s;
    center_i = c;
    mode_i = m;
    x.ci = e;
    x.fd = pcnt == 15;
    x.cyc = cyc + 2;
    sb.push_back(x);
    pcnt = pcnt == 15 ? 0 : pcnt + 1;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid_i = 1'b0;
    end
  endtask
  task automatic maybe_gap();
    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ci_o", int'(ci_o), 0);
    chk("reset_valid_o", int'(valid_o), 0);
    chk("reset_frame_done_o", int'(frame_done_o), 0);
    chk("reset_gvalid_o", int'(gvalid_o), 0);
    rst = 1'b0;
    // frame A: global with no previous frame -> ci 0; centers 20, total 320
    for (int i = 0; i < 16; i++) begin
      send(8'd20, fill(8'd0), 1'b1, 1'b0);
      if (i == 8) chk("gvalid_mid_first_frame", int'(gvalid_o), 0);
    end
    idle(2);
    chk("gvalid_after_first_frame", int'(gvalid_o), 1);
    // frame B: global vs 320; mode toggle ignored; last pixel uses old 320 (new total 438)
    send(8'd20, fill(8'd0), 1'b1, 1'b1);
    send(8'd19, fill(8'd0), 1'b1, 1'b0);
    send(8'd19, fill(8'd0), 1'b0, 1'b0);
    for (int i = 3; i < 15; i++) send(8'd30, fill(8'd0), 1'b0, 1'b1);
    send(8'd20, fill(8'd0), 1'b0, 1'b1);
    idle(2);
    // frame C: local with random gaps; mode toggle to global ignored; total 256
    send(8'd10, fill(8'd10), 1'b0, 1'b1);
    maybe_gap();
    send(8'd9, fill(8'd10), 1'b0, 1'b0);
    maybe_gap();
    send(8'd4, ramp(), 1'b0, 1'b1);
    maybe_gap();
    send(8'd3, ramp(), 1'b0, 1'b0);
    maybe_gap();
    send(8'd10, fill(8'd10), 1'b1, 1'b1);
    for (int i = 5; i < 16; i++) begin
      maybe_gap();
      send(8'd20, fill(8'd20), 1'b1, 1'b1);
    end
    // frame D: global vs 256 -> center 16 ties to 1, center 15 gives 0
    for (int i = 0; i < 16; i++) begin
      maybe_gap();
      send(i % 2 == 0 ? 8'd16 : 8'd15, fill(8'd0), 1'b1, i % 2 == 0);
    end
    idle(3);
    // partial frame then reset: in-flight results and partial totals discarded
    for (int i = 0; i < 7; i++) send(8'd10, fill(8'd10), 1'b0, 1'b1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    pcnt = 0;
    chk("midreset_ci_o", int'(ci_o), 0);
    chk("midreset_valid_o", int'(valid_o), 0);
    chk("midreset_frame_done_o", int'(frame_done_o), 0);
    chk("midreset_gvalid_o", int'(gvalid_o), 0);
    rst = 1'b0;
    // frame E: a fresh full frame must be counted from pixel 0
    for (int i = 0; i < 16; i++) send(8'd10, fill(8'd10), 1'b0, 1'b1);
    idle(4);
    chk("frame_done_pulses", fd_cnt, 5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
